// File: rtl/alu_pkg.sv
// Shared constants for the MIPS150 execute-stage ALU: datapath width,
// opcode/funct encodings and ALUop codes.
package alu_pkg;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned ALUOP_W = 4;
  localparam int unsigned SHAMT_W = 5;

  // Opcodes (instruction[31:26])
  localparam logic [OP_W-1:0] OPC_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OPC_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OPC_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OPC_SLTIU = 6'b001011;
  localparam logic [OP_W-1:0] OPC_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OPC_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OPC_XORI  = 6'b001110;
  localparam logic [OP_W-1:0] OPC_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OPC_LB    = 6'b100000;
  localparam logic [OP_W-1:0] OPC_LH    = 6'b100001;
  localparam logic [OP_W-1:0] OPC_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OPC_LBU   = 6'b100100;
  localparam logic [OP_W-1:0] OPC_LHU   = 6'b100101;
  localparam logic [OP_W-1:0] OPC_SB    = 6'b101000;
  localparam logic [OP_W-1:0] OPC_SH    = 6'b101001;
  localparam logic [OP_W-1:0] OPC_SW    = 6'b101011;

  // R-type funct codes (instruction[5:0])
  localparam logic [OP_W-1:0] FN_SLL  = 6'b000000;
  localparam logic [OP_W-1:0] FN_SRL  = 6'b000010;
  localparam logic [OP_W-1:0] FN_SRA  = 6'b000011;
  localparam logic [OP_W-1:0] FN_SLLV = 6'b000100;
  localparam logic [OP_W-1:0] FN_SRLV = 6'b000110;
  localparam logic [OP_W-1:0] FN_SRAV = 6'b000111;
  localparam logic [OP_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [OP_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [OP_W-1:0] FN_AND  = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR   = 6'b100101;
  localparam logic [OP_W-1:0] FN_XOR  = 6'b100110;
  localparam logic [OP_W-1:0] FN_NOR  = 6'b100111;
  localparam logic [OP_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [OP_W-1:0] FN_SLTU = 6'b101011;

  // ALUop codes
  localparam logic [ALUOP_W-1:0] ALU_ADDU = 4'd0;
  localparam logic [ALUOP_W-1:0] ALU_SUBU = 4'd1;
  localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd2;
  localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd3;
  localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd4;
  localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd5;
  localparam logic [ALUOP_W-1:0] ALU_XOR  = 4'd6;
  localparam logic [ALUOP_W-1:0] ALU_LUI  = 4'd7;
  localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd8;
  localparam logic [ALUOP_W-1:0] ALU_SRL  = 4'd9;
  localparam logic [ALUOP_W-1:0] ALU_SRA  = 4'd10;
  localparam logic [ALUOP_W-1:0] ALU_NOR  = 4'd11;
  localparam logic [ALUOP_W-1:0] ALU_XXX  = 4'd15;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode/funct -> ALUop decoder; funct only matters for R-type.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  output logic [ALUOP_W-1:0] alu_op_c
);

  always_comb begin
    alu_op_c = ALU_XXX;
    if (opcode == OPC_RTYPE) begin
      // Variable and immediate shifts share an op; the amount is muxed upstream into A.
      case (funct)
        FN_SLL,  FN_SLLV: alu_op_c = ALU_SLL;
        FN_SRL,  FN_SRLV: alu_op_c = ALU_SRL;
        FN_SRA,  FN_SRAV: alu_op_c = ALU_SRA;
        FN_ADDU:          alu_op_c = ALU_ADDU;
        FN_SUBU:          alu_op_c = ALU_SUBU;
        FN_AND:           alu_op_c = ALU_AND;
        FN_OR:            alu_op_c = ALU_OR;
        FN_XOR:           alu_op_c = ALU_XOR;
        FN_NOR:           alu_op_c = ALU_NOR;
        FN_SLT:           alu_op_c = ALU_SLT;
        FN_SLTU:          alu_op_c = ALU_SLTU;
        default:          alu_op_c = ALU_XXX;
      endcase
    end else begin
      // Loads and stores use the adder for base + offset.
      case (opcode)
        OPC_ADDIU:                                alu_op_c = ALU_ADDU;
        OPC_SLTI:                                 alu_op_c = ALU_SLT;
        OPC_SLTIU:                                alu_op_c = ALU_SLTU;
        OPC_ANDI:                                 alu_op_c = ALU_AND;
        OPC_ORI:                                  alu_op_c = ALU_OR;
        OPC_XORI:                                 alu_op_c = ALU_XOR;
        OPC_LUI:                                  alu_op_c = ALU_LUI;
        OPC_LB, OPC_LH, OPC_LW, OPC_LBU, OPC_LHU: alu_op_c = ALU_ADDU;
        OPC_SB, OPC_SH, OPC_SW:                   alu_op_c = ALU_ADDU;
        default:                                  alu_op_c = ALU_XXX;
      endcase
    end
  end

endmodule

// File: rtl/alu_unit.sv
// MIPS150 execute-stage ALU: decoder plus datapath. Defining ALU_OUT_REG_EN
// registers Out (1-cycle latency, async clear); otherwise Out is combinational.
module alu_unit
  import alu_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset_n,
  input  logic [OP_W-1:0]    opcode,
  input  logic [OP_W-1:0]    funct,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [ALUOP_W-1:0] ALUop,
  output logic [WIDTH-1:0]   Out
);

  logic [WIDTH-1:0]   result_c;
  logic [SHAMT_W-1:0] shamt;

  alu_op_decoder u_dec (
    .opcode   (opcode),
    .funct    (funct),
    .alu_op_c (ALUop)
  );

  // Only the low five bits of A are a shift amount; A[31:5] is ignored for shifts.
  assign shamt = A[SHAMT_W-1:0];

  always_comb begin
    result_c = '0;
    case (ALUop)
      ALU_ADDU: result_c = A + B;
      ALU_SUBU: result_c = A - B;
      ALU_SLT:  result_c = WIDTH'($signed(A) < $signed(B));
      ALU_SLTU: result_c = WIDTH'(A < B);
      ALU_AND:  result_c = A & B;
      ALU_OR:   result_c = A | B;
      ALU_XOR:  result_c = A ^ B;
      ALU_NOR:  result_c = ~(A | B);
      ALU_LUI:  result_c = B << 16;
      ALU_SLL:  result_c = B << shamt;
      ALU_SRL:  result_c = B >> shamt;
      ALU_SRA:  result_c = $unsigned($signed(B) >>> shamt);
      default:  result_c = '0;
    endcase
  end

`ifdef ALU_OUT_REG_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) Out <= '0;
    else          Out <= result_c;
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = Clock ^ Reset_n;
  assign Out = result_c;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors, a randomized sweep against
// a behavioural model, and (with ALU_OUT_REG_EN) latency/async-clear checks.
module tb_alu_unit;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_op;
  logic [31:0] out;

  int tests = 0;
  int fails = 0;

  alu_unit dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .opcode  (opcode),
    .funct   (funct),
    .A       (a),
    .B       (b),
    .ALUop   (alu_op),
    .Out     (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written directly from the instruction tables.
  function automatic logic [3:0] ref_op(input logic [5:0] opc, input logic [5:0] fn);
    logic [3:0] r;
    r = 4'd15;
    if (opc == 6'b000000) begin
      case (fn)
        6'b000000, 6'b000100: r = 4'd8;
        6'b000010, 6'b000110: r = 4'd9;
        6'b000011, 6'b000111: r = 4'd10;
        6'b100001: r = 4'd0;
        6'b100011: r = 4'd1;
        6'b100100: r = 4'd4;
        6'b100101: r = 4'd5;
        6'b100110: r = 4'd6;
        6'b100111: r = 4'd11;
        6'b101010: r = 4'd2;
        6'b101011: r = 4'd3;
        default:   r = 4'd15;
      endcase
    end else begin
      case (opc)
        6'b001001: r = 4'd0;
        6'b001010: r = 4'd2;
        6'b001011: r = 4'd3;
        6'b001100: r = 4'd4;
        6'b001101: r = 4'd5;
        6'b001110: r = 4'd6;
        6'b001111: r = 4'd7;
        6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: r = 4'd0;
        6'b101000, 6'b101001, 6'b101011: r = 4'd0;
        default: r = 4'd15;
      endcase
    end
    return r;
  endfunction

  // Reference result using wide integer arithmetic rather than the RTL's operators.
  function automatic logic [31:0] ref_out(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    longint     sx, sy;
    logic [63:0] w;
    int          sh;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = int'(x % 32);
    w  = 64'd0;
    case (op)
      4'd0:  w = {32'd0, x} + {32'd0, y};
      4'd1:  w = {32'd0, x} + {32'd0, ~y} + 64'd1;
      4'd2:  w = (sx < sy) ? 64'd1 : 64'd0;
      4'd3:  w = ({32'd0, x} < {32'd0, y}) ? 64'd1 : 64'd0;
      4'd4:  w = {32'd0, x & y};
      4'd5:  w = {32'd0, x | y};
      4'd6:  w = {32'd0, x ^ y};
      4'd7:  w = {32'd0, y} * 64'd65536;
      4'd8:  w = {32'd0, y} * (64'd1 << sh);
      4'd9:  w = {32'd0, y} / (64'd1 << sh);
      4'd10: w = {{32{y[31]}}, y} >> sh;
      4'd11: w = {32'd0, ~(x | y)};
      default: w = 64'd0;
    endcase
    return w[31:0];
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive at the falling edge, then sample once the result is visible.
  task automatic apply(input logic [5:0] opc, input logic [5:0] fn, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    opcode = opc;
    funct  = fn;
    a      = x;
    b      = y;
`ifdef ALU_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic directed(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                          input logic [31:0] x, input logic [31:0] y, input logic [31:0] exp);
    apply(opc, fn, x, y);
    chk32({tag, "_out"}, out, exp);
    chk4({tag, "_op"}, alu_op, ref_op(opc, fn));
  endtask

  logic [5:0] opc_pool [0:15];

  initial begin
    rst_n  = 1'b0;
    opcode = 6'd0;
    funct  = 6'd0;
    a      = 32'd0;
    b      = 32'd0;
    #2;
    chk32("reset_out", out, 32'h0);
    chk4("reset_op", alu_op, 4'd8);
    @(negedge clk);
    rst_n = 1'b1;

    directed("addu",  6'b000000, 6'b100001, 32'hB800B97B, 32'h2000AECA, 32'hD8016845);
    chk4("addu_code", alu_op, 4'd0);
    directed("slt",   6'b000000, 6'b101010, 32'd7, 32'hFFFFFFFA, 32'd0);
    directed("sltu",  6'b000000, 6'b101011, 32'd7, 32'hFFFFFFFA, 32'd1);
    directed("srl",   6'b000000, 6'b000010, 32'd3, 32'h10000007, 32'h02000000);
    directed("sra",   6'b000000, 6'b000011, 32'd2, 32'hFFFFFFFA, 32'hFFFFFFFE);
    directed("subu",  6'b000000, 6'b100011, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF);
    directed("lw",    6'b100011, 6'b010101, 32'h80000000, 32'hFFFF8000, 32'h7FFF8000);
    directed("lui",   6'b001111, 6'b000000, 32'h0, 32'h00001234, 32'h12340000);
    directed("bad_fn",6'b000000, 6'b111111, 32'h12345678, 32'h9ABCDEF0, 32'h0);
    chk4("bad_fn_code", alu_op, 4'd15);
    directed("sllv_hi", 6'b000000, 6'b000100, 32'hFFFFFFE4, 32'h00000001, 32'h00000010);
    directed("bad_opc", 6'b000010, 6'b100001, 32'd5, 32'd6, 32'h0);

`ifdef ALU_OUT_REG_EN
    // Output holds the previous result until the next rising edge.
    apply(6'b000000, 6'b100101, 32'hF0F00000, 32'h0000F0F0);
    @(negedge clk);
    a = 32'h0000000F;
    b = 32'h000000F0;
    #1;
    chk32("latency_hold", out, 32'hF0F0F0F0);
    @(posedge clk);
    #1;
    chk32("latency_load", out, 32'h000000FF);
    // Asynchronous clear with no clock edge, then reload on the first edge after release.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk32("async_clear", out, 32'h0);
    #1;
    rst_n = 1'b1;
    #1;
    chk32("clear_held", out, 32'h0);
    @(posedge clk);
    #1;
    chk32("reload", out, 32'h000000FF);
`endif

    opc_pool[0]  = 6'b000000; opc_pool[1]  = 6'b000000; opc_pool[2]  = 6'b000000;
    opc_pool[3]  = 6'b000000; opc_pool[4]  = 6'b100000; opc_pool[5]  = 6'b100001;
    opc_pool[6]  = 6'b100011; opc_pool[7]  = 6'b100100; opc_pool[8]  = 6'b100101;
    opc_pool[9]  = 6'b101000; opc_pool[10] = 6'b101001; opc_pool[11] = 6'b101011;
    opc_pool[12] = 6'b001010; opc_pool[13] = 6'b001011; opc_pool[14] = 6'b001110;
    opc_pool[15] = 6'($urandom_range(0, 63));

    for (int i = 0; i < 500; i++) begin
      logic [5:0]  o, f;
      logic [31:0] x, y;
      o = (i < 64) ? 6'b000000 : opc_pool[$urandom_range(0, 15)];
      f = (i < 64) ? 6'(i) : 6'($urandom_range(0, 63));
      x = $urandom();
      y = $urandom();
      if ($urandom_range(0, 3) == 0) x = 32'($urandom_range(0, 40));
      apply(o, f, x, y);
      chk4("rand_op", alu_op, ref_op(o, f));
      chk32("rand_out", out, ref_out(ref_op(o, f), x, y));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
